// File: rtl/dsp48a1_mac_ctrl_pkg.sv
// rtl/dsp48a1_mac_ctrl_pkg.sv - shared constants and FSM states for the DSP48A1 MAC controller
package dsp48a1_mac_ctrl_pkg;

  // X=M, Z=0: load the first product into P
  localparam logic [7:0] OPMODE_LOAD = 8'h01;
  // X=M, Z=P: add the product to the running sum
  localparam logic [7:0] OPMODE_ACC  = 8'h09;

  // A1 -> M -> P register stages inside the DSP slice
  localparam int DSP_PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/valid_pipe.sv
// rtl/valid_pipe.sv - sample-valid delay line with the first-sample flag at its head stage
module valid_pipe
  import dsp48a1_mac_ctrl_pkg::*;
#(
  parameter int DEPTH = DSP_PIPE_DEPTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             first_in,
  output logic [DEPTH-1:0] valid,
  output logic             first_head
);

  // Shift acceptances down the pipe; the first flag is only needed where OPMODE is chosen
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      first_head <= 1'b0;
    end else begin
      valid      <= {valid[DEPTH-2:0], valid_in};
      first_head <= valid_in & first_in;
    end
  end

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// rtl/dsp48a1_mac_ctrl.sv - dot-product sequencer driving a DSP48A1 multiply-accumulate slice
module dsp48a1_mac_ctrl
  import dsp48a1_mac_ctrl_pkg::*;
#(
  parameter int A_DATA_WIDTH = 18,
  parameter int B_DATA_WIDTH = 18,
  parameter int P_DATA_WIDTH = 48,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [LEN_WIDTH-1:0]    LEN,
  output logic                    START_READY,
  input  logic                    IN_VALID,
  input  logic [A_DATA_WIDTH-1:0] IN_A,
  input  logic [B_DATA_WIDTH-1:0] IN_B,
  output logic                    IN_READY,
  output logic                    RES_VALID,
  input  logic                    RES_READY,
  output logic [P_DATA_WIDTH-1:0] RES,
  output logic                    BUSY,
  output logic [A_DATA_WIDTH-1:0] DSP_A,
  output logic [B_DATA_WIDTH-1:0] DSP_B,
  output logic [7:0]              DSP_OPMODE,
  output logic                    DSP_CEA,
  output logic                    DSP_CEB,
  output logic                    DSP_CEM,
  output logic                    DSP_CEP,
  output logic                    DSP_CEOPMODE,
  output logic                    DSP_RST,
  input  logic [P_DATA_WIDTH-1:0] DSP_P
);

  // The A1/B1 stage is loaded directly by the acceptance, so only M and P need tracking
  localparam int PIPE_STAGES = DSP_PIPE_DEPTH - 1;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   count;
  logic                   start_fire;
  logic                   accept;
  logic                   last_accept;
  logic [PIPE_STAGES-1:0] vld;
  logic                   first_head;

  assign start_fire  = (state == IDLE) && START;
  assign IN_READY    = !RST && (state == RUN) && (count < len_q);
  assign accept      = IN_VALID && IN_READY;
  assign last_accept = accept && ((count + LEN_WIDTH'(1)) == len_q);

  // The DSP reset shares the start cycle, so P is already zero when RUN begins
  assign DSP_RST      = RST | start_fire;
  assign DSP_A        = IN_A;
  assign DSP_B        = IN_B;
  assign DSP_CEA      = accept;
  assign DSP_CEB      = accept;
  assign DSP_CEM      = vld[0] && !RST;
  assign DSP_CEP      = vld[PIPE_STAGES-1] && !RST;
  assign DSP_CEOPMODE = 1'b1;
  // OPMODE is registered inside the DSP, so it is presented alongside CEM and used with CEP
  assign DSP_OPMODE   = (vld[0] && !RST) ? (first_head ? OPMODE_LOAD : OPMODE_ACC) : 8'h00;

  // P holds still once CEP drops, so the result is read straight from the slice
  assign RES         = DSP_P;
  assign RES_VALID   = (state == DONE) && !RST;
  assign BUSY        = (state != IDLE) && !RST;
  assign START_READY = (state == IDLE) && !RST;

  valid_pipe #(
    .DEPTH(PIPE_STAGES)
  ) u_valid_pipe (
    .clk       (CLK),
    .rst       (RST),
    .valid_in  (accept),
    .first_in  (count == '0),
    .valid     (vld),
    .first_head(first_head)
  );

  // Job sequencing: latch length, count acceptances, wait for the pipe, hand off the result
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      len_q <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            len_q <= LEN;
            count <= '0;
            state <= (LEN == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            count <= count + LEN_WIDTH'(1);
            if (last_accept) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Leave once only the P stage still holds work; it commits on this same edge
          if (vld[PIPE_STAGES-2:0] == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (RES_READY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
